ssd_scan4: RTL and testbench



---
 rtl/ssd_scan4.sv | 106 ++++++++++
 tb/tb_ssd_scan4.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ssd_scan4.sv
// Four-digit multiplexed seven-segment scanner: shadows a packed BCD word and
// rotates it onto a shared active-low cathode bus. Optional: SSD_LEADING_ZERO_BLANK_EN.
module ssd_scan4 #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic        load,
  output logic [6:0]  cathodes,
  output logic [3:0]  anodes
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [15:0]      shadow;
  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic [1:0]       idx_next;
  logic             tick;
  logic [3:0]       nibble;
  logic             blank;
  logic [6:0]       seg_next;

  assign tick     = (div_cnt == CNT_W'(REFRESH_DIV - 1));
  assign idx_next = idx + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= 16'h0000;
    end else if (load) begin
      shadow <= bcd_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_comb begin
    nibble = shadow[3:0];
    case (idx_next)
      2'd0: nibble = shadow[3:0];
      2'd1: nibble = shadow[7:4];
      2'd2: nibble = shadow[11:8];
      2'd3: nibble = shadow[15:12];
      default: nibble = shadow[3:0];
    endcase
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  // A digit is blank only when it and every more-significant nibble are zero.
  always_comb begin
    blank = 1'b0;
    case (idx_next)
      2'd1: blank = (shadow[15:4] == 12'h000);
      2'd2: blank = (shadow[15:8] == 8'h00);
      2'd3: blank = (shadow[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_next = 7'b0111111;
    if (blank) begin
      seg_next = 7'b1111111;
    end else begin
      case (nibble)
        4'd0: seg_next = 7'b1000000;
        4'd1: seg_next = 7'b1111001;
        4'd2: seg_next = 7'b0100100;
        4'd3: seg_next = 7'b0110000;
        4'd4: seg_next = 7'b0011001;
        4'd5: seg_next = 7'b0010010;
        4'd6: seg_next = 7'b0000010;
        4'd7: seg_next = 7'b1111000;
        4'd8: seg_next = 7'b0000000;
        4'd9: seg_next = 7'b0010000;
        default: seg_next = 7'b0111111;
      endcase
    end
  end

  // Outputs are taken from the pre-edge shadow, so a load on a tick edge shows next slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= 2'd3;
      anodes   <= 4'b1111;
      cathodes <= 7'b1111111;
    end else if (tick) begin
      idx      <= idx_next;
      anodes   <= ~(4'b0001 << idx_next);
      cathodes <= seg_next;
    end
  end

endmodule

// File: tb/tb_ssd_scan4.sv
// Self-checking bench for ssd_scan4 (REFRESH_DIV=4) against a cycle-count reference model.
module tb_ssd_scan4;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcd_in = 16'h0000;
  logic [6:0]  cathodes;
  logic [3:0]  anodes;

  int          n_checks = 0;
  int          n_fail = 0;

  int          cyc;
  logic [15:0] m_shadow;
  logic [3:0]  m_an;
  logic [6:0]  m_cat;

`ifdef SSD_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LEAD_ZERO_EXP = 7'b1111111;
`else
  localparam logic [6:0] LEAD_ZERO_EXP = 7'b1000000;
`endif

  always #5 clk = ~clk;

  ssd_scan4 #(.REFRESH_DIV(RD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bcd_in   (bcd_in),
    .load     (load),
    .cathodes (cathodes),
    .anodes   (anodes)
  );

  function automatic logic [6:0] seg_ref(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [6:0] digit_code(input logic [15:0] sh, input int d);
    int upper;
    upper = int'(sh) >> (4 * d);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    if (d > 0 && upper == 0) return 7'b1111111;
`endif
    return seg_ref(upper % 16);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc      = 0;
    m_shadow = 16'h0000;
    m_an     = 4'b1111;
    m_cat    = 7'b1111111;
  endtask

  // Every RD-th edge since reset release shows digit ((ticks-1) mod 4) from the pre-edge shadow.
  task automatic model_edge(input logic ld, input logic [15:0] v);
    int d;
    if (!rst_n) return;
    cyc++;
    if (cyc % RD == 0) begin
      d     = ((cyc / RD) - 1) % 4;
      m_an  = ~(4'b0001 << d);
      m_cat = digit_code(m_shadow, d);
    end
    if (ld) m_shadow = v;
  endtask

  task automatic cycle(input logic ld, input logic [15:0] v);
    load   = ld;
    bcd_in = v;
    @(posedge clk);
    model_edge(ld, v);
    #1;
    load   = 1'b0;
    bcd_in = 16'($urandom);
    @(negedge clk);
    check("anodes", 32'(anodes), 32'(m_an));
    check("cathodes", 32'(cathodes), 32'(m_cat));
    if (rst_n && cyc >= RD) check("one_anode", 32'($countones(~anodes)), 32'd1);
  endtask

  initial begin
    model_reset();
    repeat (3) cycle(1'b0, 16'h0000);
    rst_n = 1'b1;

    // reset release and first tick
    repeat (3) cycle(1'b0, 16'h0000);
    cycle(1'b0, 16'h0000);
    check("first_an", 32'(anodes), 32'h0000000e);
    check("first_cat", 32'(cathodes), 32'h00000040);

    // full scan
    cycle(1'b1, 16'h1234);
    repeat (20) cycle(1'b0, 16'h0000);

    // invalid nibbles
    cycle(1'b1, 16'hA0F9);
    repeat (20) cycle(1'b0, 16'h0000);

    // load on a tick edge
    for (int i = 0; i < RD && (cyc % RD) != RD - 1; i++) cycle(1'b0, 16'h0000);
    cycle(1'b1, 16'h5555);
    repeat (8) cycle(1'b0, 16'h0000);
    for (int i = 0; i < RD && (cyc % RD) != RD - 1; i++) cycle(1'b0, 16'h0000);
    cycle(1'b1, 16'h0000);
    repeat (RD) cycle(1'b0, 16'h0000);
    check("coinc_new_val", 32'(cathodes), 32'h00000040);

    // async reset between edges
    cycle(1'b1, 16'h8888);
    repeat (6) cycle(1'b0, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    check("async_an", 32'(anodes), 32'h0000000f);
    check("async_cat", 32'(cathodes), 32'h0000007f);
    model_reset();
    #1 rst_n = 1'b1;
    repeat (20) cycle(1'b0, 16'h0000);

    // leading zeros
    cycle(1'b1, 16'h0042);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 16'h0000);
      if (anodes == 4'b0111) check("lead_d3", 32'(cathodes), 32'(LEAD_ZERO_EXP));
      if (anodes == 4'b1011) check("lead_d2", 32'(cathodes), 32'(LEAD_ZERO_EXP));
      if (anodes == 4'b1101) check("lead_d1", 32'(cathodes), 32'h00000019);
    end

    // random loads, including back-to-back ones and dash nibbles
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) cycle(1'b1, 16'($urandom));
      else if ($urandom_range(0, 7) == 0) cycle(1'b1, 16'($urandom) & 16'h0f0f);
      else cycle(1'b0, 16'h0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
